// File: rtl/disp_reg_pkg.sv
// Register map, bit positions and defaults shared by the display
// register controller and its sub-blocks.
package disp_reg_pkg;

    localparam logic [15:0] A_DISPADDR = 16'h0000;
    localparam logic [15:0] A_DISPCTRL = 16'h0004;
    localparam logic [15:0] A_DISPINT  = 16'h0008;
    localparam logic [15:0] A_DISPFIFO = 16'h000C;

    localparam int B_DISPON  = 0;
    localparam int B_VBLANK  = 1;
    localparam int B_INTENBL = 0;
    localparam int B_INTCLR  = 1;
    localparam int B_UNDER   = 0;
    localparam int B_OVER    = 1;

    localparam logic [31:0] ADDR_INIT_DEF = 32'h2000_0000;

    // One 640x480x4-byte page; informative only.
    localparam logic [31:0] VGA_FRAME = 32'd1228800;

    // Replace the bytes of old selected by be with those of wd.
    function automatic logic [31:0] be_merge(
        input logic [31:0] old,
        input logic [31:0] wd,
        input logic [3:0]  be
    );
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/disp_regctrl_if.sv
// CPU-side register bus: byte-enabled write port and
// registered read port.
interface disp_regctrl_if;
    import disp_reg_pkg::*;

    logic [15:0] WRADDR;
    logic [3:0]  BYTEEN;
    logic        WREN;
    logic [31:0] WDATA;
    logic [15:0] RDADDR;
    logic        RDEN;
    logic [31:0] RDATA;

    modport master (
        output WRADDR, BYTEEN, WREN, WDATA,
        output RDADDR, RDEN,
        input  RDATA
    );

    modport slave (
        input  WRADDR, BYTEEN, WREN, WDATA,
        input  RDADDR, RDEN,
        output RDATA
    );

endinterface

// File: rtl/disp_w1c_flag.sv
// Sticky status flag: set by an event pulse, cleared by a
// write-1, with the event winning when both land together.
module disp_w1c_flag (
    input  logic ACLK,
    input  logic ARESETN,
    input  logic set,
    input  logic clr,
    output logic q
);

    // Set has priority so an event coinciding with a clear is kept.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)  q <= 1'b0;
        else if (set)  q <= 1'b1;
        else if (clr)  q <= 1'b0;
    end

endmodule

// File: rtl/disp_regctrl.sv
// Display register controller: frame-buffer base, enable,
// interrupt and FIFO status registers on the CPU register bus.
module disp_regctrl
    import disp_reg_pkg::*;
#(
    parameter logic [31:0] P_ADDR_INIT = ADDR_INIT_DEF
) (
    input  logic          ACLK,
    input  logic          ARESETN,
    disp_regctrl_if.slave bus,
    input  logic          VBLANK_START,
    input  logic          FIFO_OVER,
    input  logic          FIFO_UNDER,
    output logic          DISPON,
    output logic [31:0]   DISPADDR_ACT,
    output logic          DSP_IRQ
);

    logic [31:0] dispaddr;
    logic        intenbl;
    logic        vblank_q;
    logic        pend_q;
    logic        under_q;
    logic        over_q;
    logic        wr_addr;
    logic        wr_ctrl;
    logic        wr_int;
    logic        wr_fifo;
    logic [31:0] rd_val;

    // Control bits sit in byte 0, so those writes need BYTEEN[0].
    always_comb begin
        wr_addr = bus.WREN && (bus.WRADDR == A_DISPADDR);
        wr_ctrl = bus.WREN && bus.BYTEEN[0]
                  && (bus.WRADDR == A_DISPCTRL);
        wr_int  = bus.WREN && bus.BYTEEN[0]
                  && (bus.WRADDR == A_DISPINT);
        wr_fifo = bus.WREN && bus.BYTEEN[0]
                  && (bus.WRADDR == A_DISPFIFO);
    end

    // Byte-enabled frame-buffer base register.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)     dispaddr <= P_ADDR_INIT;
        else if (wr_addr) dispaddr <= be_merge(dispaddr, bus.WDATA,
                                               bus.BYTEEN);
    end

    // Display enable and interrupt enable bits.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            DISPON  <= 1'b0;
            intenbl <= 1'b0;
        end else begin
            if (wr_ctrl) DISPON  <= bus.WDATA[B_DISPON];
            if (wr_int)  intenbl <= bus.WDATA[B_INTENBL];
        end
    end

    disp_w1c_flag u_vblank (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .set     (VBLANK_START),
        .clr     (wr_ctrl && bus.WDATA[B_VBLANK]),
        .q       (vblank_q)
    );

    disp_w1c_flag u_pend (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .set     (VBLANK_START),
        .clr     (wr_int && bus.WDATA[B_INTCLR]),
        .q       (pend_q)
    );

    disp_w1c_flag u_under (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .set     (FIFO_UNDER),
        .clr     (wr_fifo && bus.WDATA[B_UNDER]),
        .q       (under_q)
    );

    disp_w1c_flag u_over (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .set     (FIFO_OVER),
        .clr     (wr_fifo && bus.WDATA[B_OVER]),
        .q       (over_q)
    );

    // Active base tracks the register while idle; while the display
    // runs it only swaps at vblank so a frame never tears.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)          DISPADDR_ACT <= P_ADDR_INIT;
        else if (!DISPON)      DISPADDR_ACT <= dispaddr;
        else if (VBLANK_START) DISPADDR_ACT <= dispaddr;
    end

    // Interrupt output is the masked pending bit, one cycle late.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) DSP_IRQ <= 1'b0;
        else          DSP_IRQ <= pend_q & intenbl;
    end

    // Read mux over the full 16-bit address; holes read zero.
    always_comb begin
        rd_val = 32'h0;
        case (bus.RDADDR)
            A_DISPADDR: rd_val = dispaddr;
            A_DISPCTRL: begin
                rd_val[B_DISPON] = DISPON;
                rd_val[B_VBLANK] = vblank_q;
            end
            A_DISPINT: begin
                rd_val[B_INTENBL] = intenbl;
                rd_val[B_INTCLR]  = pend_q;
            end
            A_DISPFIFO: begin
                rd_val[B_UNDER] = under_q;
                rd_val[B_OVER]  = over_q;
            end
            default: rd_val = 32'h0;
        endcase
    end

    // Registered read data, held between reads.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)      bus.RDATA <= 32'h0;
        else if (bus.RDEN) bus.RDATA <= rd_val;
    end

endmodule

// File: tb/tb_disp_regctrl.sv
// Directed bench for disp_regctrl: reads are checked by a
// scoreboard monitor, side outputs by direct compares.
module tb_disp_regctrl;
    import disp_reg_pkg::*;

    logic        ACLK;
    logic        ARESETN;
    logic        VBLANK_START;
    logic        FIFO_OVER;
    logic        FIFO_UNDER;
    logic        DISPON;
    logic [31:0] DISPADDR_ACT;
    logic        DSP_IRQ;

    disp_regctrl_if bus ();

    disp_regctrl dut (
        .ACLK         (ACLK),
        .ARESETN      (ARESETN),
        .bus          (bus),
        .VBLANK_START (VBLANK_START),
        .FIFO_OVER    (FIFO_OVER),
        .FIFO_UNDER   (FIFO_UNDER),
        .DISPON       (DISPON),
        .DISPADDR_ACT (DISPADDR_ACT),
        .DSP_IRQ      (DSP_IRQ)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];
    logic rd_fire;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    // Tracks which edges captured a read.
    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) rd_fire <= 1'b0;
        else          rd_fire <= bus.RDEN;
    end

    // Scoreboard: compare each returned read with its expectation.
    always @(negedge ACLK) begin
        if (rd_fire) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL rdata: got %08h with no expected read",
                         bus.RDATA);
            end else begin
                chk("rdata", bus.RDATA, exp_q.pop_front());
            end
        end
    end

    task automatic op(input logic w, input logic [15:0] a,
                      input logic [3:0] be, input logic [31:0] d,
                      input logic vs, input logic fu,
                      input logic fo);
        bus.WREN     = w;
        bus.WRADDR   = a;
        bus.BYTEEN   = be;
        bus.WDATA    = d;
        VBLANK_START = vs;
        FIFO_UNDER   = fu;
        FIFO_OVER    = fo;
        @(negedge ACLK);
        bus.WREN     = 1'b0;
        VBLANK_START = 1'b0;
        FIFO_UNDER   = 1'b0;
        FIFO_OVER    = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [3:0] be,
                      input logic [31:0] d);
        op(1'b1, a, be, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pulse(input logic vs, input logic fu,
                         input logic fo);
        op(1'b0, 16'h0, 4'h0, 32'h0, vs, fu, fo);
    endtask

    task automatic rd(input logic [15:0] a, input logic [31:0] e);
        bus.RDADDR = a;
        bus.RDEN   = 1'b1;
        exp_q.push_back(e);
        @(negedge ACLK);
        bus.RDEN   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge ACLK);
    endtask

    initial begin
        ARESETN      = 1'b0;
        bus.WREN     = 1'b0;
        bus.WRADDR   = 16'h0;
        bus.BYTEEN   = 4'h0;
        bus.WDATA    = 32'h0;
        bus.RDEN     = 1'b0;
        bus.RDADDR   = 16'h0;
        VBLANK_START = 1'b0;
        FIFO_OVER    = 1'b0;
        FIFO_UNDER   = 1'b0;

        idle(2);
        chk("rst_rdata", bus.RDATA, 32'h0);
        chk("rst_dispon", {31'h0, DISPON}, 32'h0);
        chk("rst_act", DISPADDR_ACT, 32'h2000_0000);
        chk("rst_irq", {31'h0, DSP_IRQ}, 32'h0);
        ARESETN = 1'b1;
        idle(1);

        // Byte-enabled writes to DISPADDR.
        wr(A_DISPADDR, 4'b0001, 32'h1234_5678);
        rd(A_DISPADDR, 32'h2000_0078);
        wr(A_DISPADDR, 4'b0010, 32'h0000_5600);
        rd(A_DISPADDR, 32'h2000_5678);
        wr(A_DISPADDR, 4'b0100, 32'h0034_0000);
        rd(A_DISPADDR, 32'h2034_5678);
        wr(A_DISPADDR, 4'b1000, 32'h1200_0000);
        rd(A_DISPADDR, 32'h1234_5678);
        chk("act_follow0", DISPADDR_ACT, 32'h1234_5678);

        // Active address follows when off, swaps at vblank when on.
        wr(A_DISPADDR, 4'hF, 32'h2012_C000);
        idle(1);
        chk("act_follow1", DISPADDR_ACT, 32'h2012_C000);
        wr(A_DISPCTRL, 4'h1, 32'h1);
        chk("dispon_on", {31'h0, DISPON}, 32'h1);
        wr(A_DISPADDR, 4'hF, 32'h2000_0000);
        idle(2);
        chk("act_hold", DISPADDR_ACT, 32'h2012_C000);
        rd(A_DISPADDR, 32'h2000_0000);
        pulse(1'b1, 1'b0, 1'b0);
        chk("act_swap", DISPADDR_ACT, 32'h2000_0000);

        // VBLANK sticky flag.
        rd(A_DISPCTRL, 32'h3);
        wr(A_DISPCTRL, 4'h1, 32'h3);
        rd(A_DISPCTRL, 32'h1);
        op(1'b1, A_DISPCTRL, 4'h1, 32'h3, 1'b1, 1'b0, 1'b0);
        rd(A_DISPCTRL, 32'h3);

        // Interrupt pending and masked DSP_IRQ.
        wr(A_DISPINT, 4'h1, 32'h2);
        rd(A_DISPINT, 32'h0);
        wr(A_DISPINT, 4'h1, 32'h3);
        pulse(1'b1, 1'b0, 1'b0);
        chk("irq_lag", {31'h0, DSP_IRQ}, 32'h0);
        idle(1);
        chk("irq_set", {31'h0, DSP_IRQ}, 32'h1);
        rd(A_DISPINT, 32'h3);
        wr(A_DISPINT, 4'h1, 32'h3);
        idle(1);
        chk("irq_clr", {31'h0, DSP_IRQ}, 32'h0);
        rd(A_DISPINT, 32'h1);
        wr(A_DISPINT, 4'h1, 32'h0);
        pulse(1'b1, 1'b0, 1'b0);
        idle(2);
        chk("irq_masked", {31'h0, DSP_IRQ}, 32'h0);
        rd(A_DISPINT, 32'h2);

        // FIFO flags, unmapped addresses, byte-0 gating.
        pulse(1'b0, 1'b1, 1'b1);
        rd(A_DISPFIFO, 32'h3);
        wr(A_DISPFIFO, 4'h1, 32'h1);
        rd(A_DISPFIFO, 32'h2);
        wr(A_DISPFIFO, 4'h1, 32'h2);
        rd(A_DISPFIFO, 32'h0);
        rd(16'h0010, 32'h0);
        wr(16'h0100, 4'hF, 32'hDEAD_BEEF);
        wr(16'h0010, 4'hF, 32'hDEAD_BEEF);
        rd(A_DISPADDR, 32'h2000_0000);
        wr(A_DISPCTRL, 4'b1110, 32'h0);
        chk("be0_gate", {31'h0, DISPON}, 32'h1);
        rd(A_DISPCTRL, 32'h3);

        // Everything set, then reset in the middle of a read.
        pulse(1'b1, 1'b1, 1'b1);
        wr(A_DISPINT, 4'h1, 32'h1);
        idle(1);
        chk("irq_pre_rst", {31'h0, DSP_IRQ}, 32'h1);
        bus.RDADDR = A_DISPCTRL;
        bus.RDEN   = 1'b1;
        #2 ARESETN = 1'b0;
        #1;
        chk("mid_rst_rdata", bus.RDATA, 32'h0);
        chk("mid_rst_irq", {31'h0, DSP_IRQ}, 32'h0);
        chk("mid_rst_dispon", {31'h0, DISPON}, 32'h0);
        chk("mid_rst_act", DISPADDR_ACT, 32'h2000_0000);
        bus.RDEN = 1'b0;
        idle(1);
        ARESETN = 1'b1;
        idle(1);
        rd(A_DISPADDR, 32'h2000_0000);
        rd(A_DISPCTRL, 32'h0);
        rd(A_DISPINT, 32'h0);
        rd(A_DISPFIFO, 32'h0);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) idle(1);
        if (exp_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: got %0d reads outstanding expected 0",
                     exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
